// File: rtl/jtag_tap_responder.sv
// JTAG TAP responder oversampled on the system clock: IDCODE, BYPASS and one user DR.
// Optional JTAG_TAP_TRST_EN: synchronized jtag_TRSTn low holds the TAP in Test-Logic-Reset.
module jtag_tap_responder #(
  parameter int unsigned          IR_WIDTH      = 5,
  parameter logic [31:0]          IDCODE_VALUE  = 32'h20000913,
  parameter logic [IR_WIDTH-1:0]  IDCODE_INSTR  = 5'h01,
  parameter logic [IR_WIDTH-1:0]  USER_INSTR    = 5'h11,
  parameter int unsigned          USER_DR_WIDTH = 41
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     jtag_TCK,
  input  logic                     jtag_TMS,
  input  logic                     jtag_TDI,
  input  logic                     jtag_TRSTn,
  output logic                     jtag_TDO_data,
  output logic                     jtag_TDO_driven,
  output logic                     user_capture,
  input  logic [USER_DR_WIDTH-1:0] user_capture_data,
  output logic                     user_update_valid,
  output logic [USER_DR_WIDTH-1:0] user_update_data,
  output logic [3:0]               tap_state
);

  localparam logic [3:0] TEST_LOGIC_RESET = 4'hF;
  localparam logic [3:0] RUN_TEST_IDLE    = 4'hC;
  localparam logic [3:0] SELECT_DR_SCAN   = 4'h7;
  localparam logic [3:0] CAPTURE_DR       = 4'h6;
  localparam logic [3:0] SHIFT_DR         = 4'h2;
  localparam logic [3:0] EXIT1_DR         = 4'h1;
  localparam logic [3:0] PAUSE_DR         = 4'h3;
  localparam logic [3:0] EXIT2_DR         = 4'h0;
  localparam logic [3:0] UPDATE_DR        = 4'h5;
  localparam logic [3:0] SELECT_IR_SCAN   = 4'h4;
  localparam logic [3:0] CAPTURE_IR       = 4'hE;
  localparam logic [3:0] SHIFT_IR         = 4'hA;
  localparam logic [3:0] EXIT1_IR         = 4'h9;
  localparam logic [3:0] PAUSE_IR         = 4'hB;
  localparam logic [3:0] EXIT2_IR         = 4'h8;
  localparam logic [3:0] UPDATE_IR        = 4'hD;

  logic tck_p0, tck_p1, tck_p2;
  logic tms_p0, tms_p1;
  logic tdi_p0, tdi_p1;
  logic trstn_p0, trstn_p1;

  logic [3:0]               state;
  logic [3:0]               state_next;
  logic [IR_WIDTH-1:0]      ir;
  logic [IR_WIDTH-1:0]      ir_sr;
  logic [31:0]              id_sr;
  logic [USER_DR_WIDTH-1:0] user_sr;
  logic                     byp_sr;

  logic tck_rise, tck_fall, trst_active, do_rise;
  logic sel_idcode, sel_user, dr_lsb;

  // Stage p0/p1: two-flop synchronizers; p2: previous TCK for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tck_p0   <= 1'b0;
      tck_p1   <= 1'b0;
      tck_p2   <= 1'b0;
      tms_p0   <= 1'b0;
      tms_p1   <= 1'b0;
      tdi_p0   <= 1'b0;
      tdi_p1   <= 1'b0;
      trstn_p0 <= 1'b0;
      trstn_p1 <= 1'b0;
    end else begin
      tck_p0   <= jtag_TCK;
      tck_p1   <= tck_p0;
      tck_p2   <= tck_p1;
      tms_p0   <= jtag_TMS;
      tms_p1   <= tms_p0;
      tdi_p0   <= jtag_TDI;
      tdi_p1   <= tdi_p0;
      trstn_p0 <= jtag_TRSTn;
      trstn_p1 <= trstn_p0;
    end
  end

  assign tck_rise = tck_p1 & ~tck_p2;
  assign tck_fall = ~tck_p1 & tck_p2;

`ifdef JTAG_TAP_TRST_EN
  assign trst_active = ~trstn_p1;
`else
  logic trst_unused;
  assign trst_unused = trstn_p1;
  assign trst_active = 1'b0;
`endif

  // A test reset on the same clock as a rise suppresses every state action
  assign do_rise    = tck_rise & ~trst_active;
  assign sel_idcode = (ir == IDCODE_INSTR);
  assign sel_user   = (ir == USER_INSTR);
  assign dr_lsb     = sel_idcode ? id_sr[0] : (sel_user ? user_sr[0] : byp_sr);
  assign tap_state  = state;

  always_comb begin
    state_next = state;
    case (state)
      TEST_LOGIC_RESET: state_next = tms_p1 ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_next = tms_p1 ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_next = tms_p1 ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms_p1 ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_next = tms_p1 ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_next = tms_p1 ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_next = tms_p1 ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_next = tms_p1 ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_next = tms_p1 ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_next = tms_p1 ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms_p1 ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_next = tms_p1 ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_next = tms_p1 ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_next = tms_p1 ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_next = tms_p1 ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_next = tms_p1 ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

  // Stage p3: FSM, instruction latch, strobes and TDO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= TEST_LOGIC_RESET;
      ir                <= IDCODE_INSTR;
      jtag_TDO_data     <= 1'b0;
      jtag_TDO_driven   <= 1'b0;
      user_capture      <= 1'b0;
      user_update_valid <= 1'b0;
      user_update_data  <= '0;
    end else begin
      user_capture      <= 1'b0;
      user_update_valid <= 1'b0;
      if (trst_active) begin
        state           <= TEST_LOGIC_RESET;
        ir              <= IDCODE_INSTR;
        jtag_TDO_driven <= 1'b0;
      end else begin
        if (tck_rise) begin
          state <= state_next;
          if (state_next == TEST_LOGIC_RESET) ir <= IDCODE_INSTR;
          if (state_next == UPDATE_IR) ir <= ir_sr;
          if (state_next == CAPTURE_DR && sel_user) user_capture <= 1'b1;
          if (state_next == UPDATE_DR && sel_user) begin
            user_update_valid <= 1'b1;
            user_update_data  <= user_sr;
          end
        end
        if (tck_fall) begin
          if (state == SHIFT_IR) begin
            jtag_TDO_data   <= ir_sr[0];
            jtag_TDO_driven <= 1'b1;
          end else if (state == SHIFT_DR) begin
            jtag_TDO_data   <= dr_lsb;
            jtag_TDO_driven <= 1'b1;
          end else begin
            jtag_TDO_driven <= 1'b0;
          end
        end
      end
    end
  end

  // Stage p3 datapath: shift registers are always reloaded by a capture before use
  always_ff @(posedge clock) begin
    if (do_rise) begin
      if (state == SHIFT_IR) ir_sr <= {tdi_p1, ir_sr[IR_WIDTH-1:1]};
      if (state_next == CAPTURE_IR) ir_sr <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
      if (state == SHIFT_DR) begin
        if (sel_idcode)    id_sr   <= {tdi_p1, id_sr[31:1]};
        else if (sel_user) user_sr <= {tdi_p1, user_sr[USER_DR_WIDTH-1:1]};
        else               byp_sr  <= tdi_p1;
      end
      if (state_next == CAPTURE_DR) begin
        if (sel_idcode)    id_sr   <= IDCODE_VALUE;
        else if (sel_user) user_sr <= user_capture_data;
        else               byp_sr  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Randomized bench for jtag_tap_responder with a queue-based TAP model and directed literal checks.
module tb_jtag_tap_responder;
  localparam int UW = 41;
  localparam logic [31:0] IDCODE = 32'h20000913;
  localparam logic [4:0]  I_ID   = 5'h01;
  localparam logic [4:0]  I_USER = 5'h11;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDR = 4'h7, S_CDR = 4'h6,
                         S_SHDR = 4'h2, S_E1DR = 4'h1, S_PDR = 4'h3, S_E2DR = 4'h0,
                         S_UDR = 4'h5, S_SIR = 4'h4, S_CIR = 4'hE, S_SHIR = 4'hA,
                         S_E1IR = 4'h9, S_PIR = 4'hB, S_E2IR = 4'h8, S_UIR = 4'hD;

  logic clock = 1'b0;
  logic reset;
  logic jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
  logic jtag_TDO_data, jtag_TDO_driven;
  logic user_capture, user_update_valid;
  logic [UW-1:0] user_capture_data, user_update_data;
  logic [3:0] tap_state;

  always #5 clock = ~clock;

  jtag_tap_responder dut (
    .clock(clock), .reset(reset),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
    .user_capture(user_capture), .user_capture_data(user_capture_data),
    .user_update_valid(user_update_valid), .user_update_data(user_update_data),
    .tap_state(tap_state)
  );

  // Reference model: transition table plus bit queues for the shift paths
  logic [3:0]    m_next [16][2];
  logic [3:0]    m_state;
  logic [4:0]    m_ir;
  bit            ir_q[$];
  bit            dr_q[$];
  bit            exp_data, exp_driven;
  logic [UW-1:0] exp_upd_data;
  int            exp_cap, exp_upd, cap_seen, upd_seen;
  int            errors, checks;
  bit            settled;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void set_tr(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
    m_next[s][0] = n0;
    m_next[s][1] = n1;
  endfunction

  function automatic logic [63:0] qval(input bit q[$]);
    logic [63:0] v = '0;
    for (int i = 0; i < q.size(); i++) v[i] = q[i];
    return v;
  endfunction

  function automatic void model_reset();
    m_state = S_TLR; m_ir = I_ID; exp_data = 1'b0; exp_driven = 1'b0;
    exp_upd_data = '0; ir_q = {}; dr_q = {};
  endfunction

  function automatic void model_rise(input bit tms, input bit tdi);
    logic [3:0]  nxt;
    logic [63:0] v;
    nxt = m_next[m_state][tms];
    if (m_state == S_SHIR) begin void'(ir_q.pop_front()); ir_q.push_back(tdi); end
    if (m_state == S_SHDR) begin void'(dr_q.pop_front()); dr_q.push_back(tdi); end
    m_state = nxt;
    case (nxt)
      S_TLR: m_ir = I_ID;
      S_CIR: begin
        ir_q = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      end
      S_UIR: begin v = qval(ir_q); m_ir = v[4:0]; end
      S_CDR: begin
        dr_q = {};
        if (m_ir == I_ID) begin
          for (int i = 0; i < 32; i++) dr_q.push_back(IDCODE[i]);
        end else if (m_ir == I_USER) begin
          for (int i = 0; i < UW; i++) dr_q.push_back(user_capture_data[i]);
          exp_cap++;
        end else begin
          dr_q.push_back(1'b0);
        end
      end
      S_UDR: if (m_ir == I_USER) begin
        v = qval(dr_q); exp_upd_data = v[UW-1:0]; exp_upd++;
      end
      default: ;
    endcase
  endfunction

  function automatic void model_fall();
    if (m_state == S_SHIR) begin exp_data = ir_q[0]; exp_driven = 1'b1; end
    else if (m_state == S_SHDR) begin exp_data = dr_q[0]; exp_driven = 1'b1; end
    else exp_driven = 1'b0;
  endfunction

  function automatic void model_trst();
`ifdef JTAG_TAP_TRST_EN
    m_state = S_TLR; m_ir = I_ID; exp_driven = 1'b0;
`endif
  endfunction

  always @(negedge clock) begin
    if (user_capture) cap_seen++;
    if (user_update_valid) begin
      upd_seen++;
      chk("upd_data_at_strobe", 64'(user_update_data), 64'(exp_upd_data));
    end
    if (settled) begin
      chk("tap_state", 64'(tap_state), 64'(m_state));
      chk("tdo_driven", 64'(jtag_TDO_driven), 64'(exp_driven));
      chk("tdo_data", 64'(jtag_TDO_data), 64'(exp_data));
      chk("update_data", 64'(user_update_data), 64'(exp_upd_data));
      chk("capture_count", 64'(cap_seen), 64'(exp_cap));
      chk("update_count", 64'(upd_seen), 64'(exp_upd));
    end
  end

  task automatic tck(input bit tms, input bit tdi, output bit tdo);
    @(posedge clock); #1;
    jtag_TMS = tms; jtag_TDI = tdi;
    repeat (3) @(posedge clock); #1;
    settled = 1'b0; jtag_TCK = 1'b1; model_rise(tms, tdi);
    repeat (3) @(posedge clock); #1 settled = 1'b1;
    repeat (3) @(posedge clock); #1;
    settled = 1'b0; jtag_TCK = 1'b0; model_fall();
    repeat (3) @(posedge clock); #1 settled = 1'b1;
    tdo = jtag_TDO_data;
  endtask

  // Runs a full scan from Run-Test-Idle back to Run-Test-Idle
  task automatic scan(input bit ir_path, input logic [63:0] din, input int n, output logic [63:0] dout);
    bit b;
    dout = '0;
    tck(1'b1, 1'b0, b);
    if (ir_path) tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b0, b);
    dout[0] = b;
    for (int i = 0; i < n; i++) begin
      tck(i == n - 1, din[i], b);
      if (i < n - 1) dout[i+1] = b;
    end
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
  endtask

  task automatic to_rti();
    bit b;
    repeat (5) tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
  endtask

  task automatic pulse_reset();
    settled = 1'b0;
    reset = 1'b1; model_reset();
    repeat (2) @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(posedge clock); #1 settled = 1'b1;
  endtask

  initial begin
    logic [63:0] d;
    logic [4:0]  ir_pick;
    int c0, u0;
    bit b;
    set_tr(S_TLR, S_RTI, S_TLR);   set_tr(S_RTI, S_RTI, S_SDR);
    set_tr(S_SDR, S_CDR, S_SIR);   set_tr(S_CDR, S_SHDR, S_E1DR);
    set_tr(S_SHDR, S_SHDR, S_E1DR); set_tr(S_E1DR, S_PDR, S_UDR);
    set_tr(S_PDR, S_PDR, S_E2DR);  set_tr(S_E2DR, S_SHDR, S_UDR);
    set_tr(S_UDR, S_RTI, S_SDR);   set_tr(S_SIR, S_CIR, S_TLR);
    set_tr(S_CIR, S_SHIR, S_E1IR); set_tr(S_SHIR, S_SHIR, S_E1IR);
    set_tr(S_E1IR, S_PIR, S_UIR);  set_tr(S_PIR, S_PIR, S_E2IR);
    set_tr(S_E2IR, S_SHIR, S_UIR); set_tr(S_UIR, S_RTI, S_SDR);
    errors = 0; checks = 0; exp_cap = 0; exp_upd = 0; cap_seen = 0; upd_seen = 0;
    settled = 1'b0; reset = 1'b0;
    jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0; jtag_TRSTn = 1'b1;
    user_capture_data = '0;
    #2 reset = 1'b1; model_reset();
    repeat (4) @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(posedge clock); #1 settled = 1'b1;
    chk("reset_state", 64'(tap_state), 64'hF);
    chk("reset_driven", 64'(jtag_TDO_driven), 64'h0);
    chk("reset_tdo", 64'(jtag_TDO_data), 64'h0);
    chk("reset_upd_data", 64'(user_update_data), 64'h0);
    tck(1'b0, 1'b0, b);

    scan(1'b0, 64'h0, 32, d);
    chk("idcode_read", 64'(d[31:0]), 64'h20000913);
    scan(1'b1, 64'h1F, 5, d);
    chk("ir_capture", 64'(d[4:0]), 64'h01);
    scan(1'b0, 64'h1, 4, d);
    chk("bypass_echo", 64'(d[3:0]), 64'h2);

    scan(1'b1, 64'(I_USER), 5, d);
    user_capture_data = 41'h1_2345_6789;
    c0 = cap_seen; u0 = upd_seen;
    scan(1'b0, 64'h0_DEAD_BEEF, UW, d);
    chk("user_shift_out", 64'(d[UW-1:0]), 64'h1_2345_6789);
    chk("user_capture_pulses", 64'(cap_seen - c0), 64'h1);
    chk("user_update_pulses", 64'(upd_seen - u0), 64'h1);
    chk("user_update_value", 64'(user_update_data), 64'h0_DEAD_BEEF);
    user_capture_data = 41'h0AB_CDEF_0123;
    repeat (8) @(posedge clock); #1;
    chk("user_data_stable", 64'(user_update_data), 64'h0_DEAD_BEEF);

    scan(1'b1, 64'h1F, 5, d);
    u0 = upd_seen;
    tck(1'b1, 1'b0, b); tck(1'b0, 1'b0, b); tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b1, b); tck(1'b0, 1'b0, b);
    repeat (5) tck(1'b1, 1'b0, b);
    chk("tms_reset_state", 64'(tap_state), 64'hF);
    chk("tms_reset_no_update", 64'(upd_seen - u0), 64'h0);
    tck(1'b0, 1'b0, b);
    scan(1'b0, 64'h0, 32, d);
    chk("ir_idcode_after_tms_reset", 64'(d[31:0]), 64'h20000913);

    scan(1'b1, 64'(I_USER), 5, d);
    c0 = cap_seen; u0 = upd_seen;
    tck(1'b1, 1'b0, b); tck(1'b0, 1'b0, b); tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b1, b); tck(1'b0, 1'b1, b);
    chk("mid_shift_driven", 64'(jtag_TDO_driven), 64'h1);
    c0 = cap_seen;
    pulse_reset();
    chk("async_reset_state", 64'(tap_state), 64'hF);
    chk("async_reset_driven", 64'(jtag_TDO_driven), 64'h0);
    chk("async_reset_no_update", 64'(upd_seen - u0), 64'h0);
    chk("async_reset_no_capture", 64'(cap_seen - c0), 64'h0);
    chk("async_reset_upd_data", 64'(user_update_data), 64'h0);

    tck(1'b0, 1'b0, b); tck(1'b1, 1'b0, b); tck(1'b0, 1'b0, b);
    tck(1'b1, 1'b0, b); tck(1'b0, 1'b0, b);
    chk("pause_dr_state", 64'(tap_state), 64'h3);
    settled = 1'b0;
    jtag_TRSTn = 1'b0; model_trst();
    repeat (4) @(posedge clock); #1 jtag_TRSTn = 1'b1;
    repeat (3) @(posedge clock); #1 settled = 1'b1;
`ifdef JTAG_TAP_TRST_EN
    chk("trst_state", 64'(tap_state), 64'hF);
`else
    chk("trst_ignored_state", 64'(tap_state), 64'h3);
`endif
    to_rti();

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          repeat ($urandom_range(3, 12)) tck(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b);
          to_rti();
        end
        1: begin
          case ($urandom_range(0, 2))
            0: ir_pick = I_ID;
            1: ir_pick = I_USER;
            default: ir_pick = 5'($urandom());
          endcase
          scan(1'b1, 64'(ir_pick), 5, d);
        end
        2: begin
          user_capture_data = UW'({$urandom(), $urandom()});
          scan(1'b0, {$urandom(), $urandom()}, $urandom_range(1, 64), d);
        end
        default: begin
          scan(1'b1, 64'(I_USER), 5, d);
          user_capture_data = UW'({$urandom(), $urandom()});
          scan(1'b0, {$urandom(), $urandom()}, UW, d);
        end
      endcase
    end
    to_rti();
    settled = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtag_tap_responder.md
Name: jtag_tap_responder

Overview:
- Synthesizable JTAG TAP (responder end) clocked entirely on the system clock.
- Oversamples externally driven TCK/TMS/TDI/TRSTn and runs the IEEE 1149.1 16-state TAP FSM.
- Implements IDCODE, BYPASS and one user data register with capture/update strobes toward a debug module.
- Drives TDO as data plus driven pair, matching the simulation JTAG driver's TDO inputs.

Parameters:
- IR_WIDTH, 5: instruction register width.
- IDCODE_VALUE, 32'h20000913: value captured by IDCODE; bit 0 must be 1.
- IDCODE_INSTR, 5'h01: IR code selecting IDCODE.
- USER_INSTR, 5'h11: IR code selecting the user DR.
- USER_DR_WIDTH, 41: user DR length (range 2..64).

Ports:
- clock  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- jtag_TCK  input  1  test clock, asynchronous to clock.
- jtag_TMS  input  1  mode select.
- jtag_TDI  input  1  serial data in.
- jtag_TRSTn  input  1  active-low test reset.
- jtag_TDO_data  output  1  serial data out.
- jtag_TDO_driven  output  1  high while TDO is valid (Shift-IR/Shift-DR).
- user_capture  output  1  one-cycle pulse on Capture-DR with USER selected.
- user_capture_data  input  USER_DR_WIDTH  loaded into the DR on user_capture.
- user_update_valid  output  1  one-cycle pulse on Update-DR with USER selected.
- user_update_data  output  USER_DR_WIDTH  DR contents; stable while user_update_valid is high.
- tap_state  output  4  current FSM state (debug).

Behaviour:
- Reset values (asynchronous reset asserted):
  - state = TEST_LOGIC_RESET; IR = IDCODE_INSTR.
  - TDO_data = 0, TDO_driven = 0.
  - Both strobes 0; user_update_data = 0; all synchronizers 0.
- Input sampling:
  - TCK, TMS, TDI, TRSTn each pass through a 2-flop synchronizer.
  - A third TCK flop detects edges.
  - A TCK rise event is the cycle where the synchronized TCK = 1 and the previous value = 0; a fall event is the reverse.
  - Requirement: TCK high and low each last at least 3 clocks. Shorter pulses are undefined.
- On a rise event:
  - The FSM advances on synchronized TMS.
  - In Shift-IR/Shift-DR the selected register shifts right, with TDI entering the MSB.
  - All 16 standard states and transitions apply.
  - Five consecutive rises with TMS=1 reach TEST_LOGIC_RESET from any state.
- State actions (performed on the rise that enters the state):
  - TEST_LOGIC_RESET: IR = IDCODE_INSTR.
  - Capture-IR: IR shift reg = {0..., 2'b01}.
  - Update-IR: IR latched from the shift reg.
  - Capture-DR:
    - IDCODE: load IDCODE_VALUE (32 bits).
    - USER: load user_capture_data and pulse user_capture in the same cycle.
    - Any other IR code: BYPASS, load a 1-bit 0.
  - Update-DR: with USER selected, user_update_data = DR and user_update_valid pulses for 1 cycle.
- On a fall event:
  - TDO_data = LSB of the active shift reg.
  - TDO_driven = 1 iff state is Shift-IR or Shift-DR; otherwise driven = 0 and data holds.
- Each strobe fires at most once per TCK cycle.
- A user_capture_data change outside the capture cycle has no effect.
- Simultaneous TRSTn low and a rise event: reset wins; no state action occurs.
- Reset mid-shift: the partial shift is discarded and no update strobe fires.

Optional Feature:
- Macro: JTAG_TAP_TRST_EN.
- Defined: synchronized jtag_TRSTn = 0 forces state = TEST_LOGIC_RESET and IR = IDCODE_INSTR on every clock while low. TDO_driven drops to 0 on the next clock.
- Undefined: jtag_TRSTn is ignored; only the TMS sequence and reset return the TAP to TEST_LOGIC_RESET.

Test Plan:
- IDCODE read: reset, TMS sequence to Shift-DR, 32 TCK cycles -> TDO bits LSB-first equal 32'h20000913; driven = 1 only during the shift.
- IR capture: shift IR with TDI = 5'b11111 -> TDO emits 1,0,0,0,0; after Update-IR, Shift-DR with 1 in then 0s -> bypass echoes the 1 delayed by one TCK.
- User DR: load IR = 5'h11, user_capture_data = 41'h1_2345_6789 -> one user_capture pulse; TDO shifts out that value; shift in 41'h0_DEAD_BEEF -> single user_update_valid with user_update_data = 41'h0_DEAD_BEEF.
- TMS reset: from Shift-DR apply 5 rises with TMS=1 -> tap_state = TEST_LOGIC_RESET, IR = 5'h01, no user_update_valid.
- Asynchronous reset in mid Shift-DR, then release -> tap_state = TEST_LOGIC_RESET, TDO_driven = 0, no strobes.
- With JTAG_TAP_TRST_EN: TRSTn low 4 clocks during Pause-DR -> TEST_LOGIC_RESET; without the macro -> state unchanged.
